// File: rtl/mac_special_case_sequencer.sv
// Front-end sequencer for an A*B+C single-precision MAC: classifies operands, resolves
// IEEE special cases on a bypass path and dispatches ordinary triples to the datapath.
module mac_special_case_sequencer #(
    parameter int PARM_XLEN = 32,
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_CNT  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PARM_XLEN-1:0] A_i,
    input  logic [PARM_XLEN-1:0] B_i,
    input  logic [PARM_XLEN-1:0] C_i,
    output logic                 dp_start_o,
    output logic [PARM_XLEN-1:0] dp_A_o,
    output logic [PARM_XLEN-1:0] dp_B_o,
    output logic [PARM_XLEN-1:0] dp_C_o,
    input  logic                 dp_done_i,
    input  logic [PARM_XLEN-1:0] dp_result_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PARM_XLEN-1:0] result_o,
    output logic                 bypass_o,
    output logic                 invalid_o,
    output logic [PARM_CNT-1:0]  bypass_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_DISPATCH,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic sign;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } op_class_t;

    localparam logic [PARM_XLEN-1:0] QNAN =
        {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

    function automatic op_class_t classify(input logic [PARM_XLEN-1:0] op);
        op_class_t c;
        logic exp_zero, exp_full, mant_zero;
        exp_zero  = (op[PARM_MANT +: PARM_EXP] == '0);
        exp_full  = (op[PARM_MANT +: PARM_EXP] == '1);
        mant_zero = (op[PARM_MANT-1:0] == '0);
        c.sign = op[PARM_XLEN-1];
        c.zero = exp_zero & mant_zero;
        c.inf  = exp_full & mant_zero;
        c.nan  = exp_full & ~mant_zero;
        c.snan = c.nan & ~op[PARM_MANT-1];
        return c;
    endfunction

    state_t               state;
    logic [PARM_XLEN-1:0] a_q, b_q, c_q;

    op_class_t            cls_a, cls_b, cls_c;
    logic                 inf_times_zero, prod_inf, prod_sign;
    logic                 byp_hit, byp_invalid;
    logic [PARM_XLEN-1:0] byp_result;

    assign cls_a = classify(a_q);
    assign cls_b = classify(b_q);
    assign cls_c = classify(c_q);

    assign inf_times_zero = (cls_a.inf & cls_b.zero) | (cls_a.zero & cls_b.inf);
    assign prod_inf       = cls_a.inf | cls_b.inf;
    assign prod_sign      = cls_a.sign ^ cls_b.sign;

    // Special-case rules in priority order; the first match decides the bypass result.
    always_comb begin
        byp_hit     = 1'b1;
        byp_invalid = 1'b0;
        byp_result  = QNAN;
        if (cls_a.nan | cls_b.nan | cls_c.nan) begin
            byp_invalid = cls_a.snan | cls_b.snan | cls_c.snan | inf_times_zero;
        end else if (inf_times_zero) begin
            byp_invalid = 1'b1;
        end else if (prod_inf & cls_c.inf & (cls_c.sign != prod_sign)) begin
            byp_invalid = 1'b1;
        end else if (prod_inf) begin
            byp_result = {prod_sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
        end else if (cls_c.inf) begin
            byp_result = c_q;
        end else begin
            byp_hit = 1'b0;
        end
    end

    assign dp_A_o = a_q;
    assign dp_B_o = b_q;
    assign dp_C_o = c_q;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            in_ready_o   <= 1'b1;
            dp_start_o   <= 1'b0;
            out_valid_o  <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            result_o     <= '0;
            bypass_o     <= 1'b0;
            invalid_o    <= 1'b0;
            bypass_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= A_i;
                        b_q        <= B_i;
                        c_q        <= C_i;
                        in_ready_o <= 1'b0;
                        state      <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (byp_hit) begin
                        result_o    <= byp_result;
                        invalid_o   <= byp_invalid;
                        bypass_o    <= 1'b1;
                        out_valid_o <= 1'b1;
                        if (bypass_cnt_o != '1) begin
                            bypass_cnt_o <= bypass_cnt_o + 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        dp_start_o <= 1'b1;
                        state      <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    dp_start_o <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dp_done_i) begin
                        result_o    <= dp_result_i;
                        bypass_o    <= 1'b0;
                        invalid_o   <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_special_case_sequencer.sv
// Directed bench for mac_special_case_sequencer: bypass rules, datapath dispatch,
// back-pressure, mid-operation reset and bypass counter saturation (narrow counter).
module tb_mac_special_case_sequencer;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [XLEN-1:0]  A_i = '0, B_i = '0, C_i = '0;
    logic             dp_start_o;
    logic [XLEN-1:0]  dp_A_o, dp_B_o, dp_C_o;
    logic             dp_done_i = 1'b0;
    logic [XLEN-1:0]  dp_result_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [XLEN-1:0]  result_o;
    logic             bypass_o;
    logic             invalid_o;
    logic [CNT_W-1:0] bypass_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk_i = ~clk_i;

    mac_special_case_sequencer #(.PARM_CNT(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .A_i(A_i), .B_i(B_i), .C_i(C_i),
        .dp_start_o(dp_start_o), .dp_A_o(dp_A_o), .dp_B_o(dp_B_o), .dp_C_o(dp_C_o),
        .dp_done_i(dp_done_i), .dp_result_i(dp_result_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .bypass_o(bypass_o), .invalid_o(invalid_o),
        .bypass_cnt_o(bypass_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle N+2 (edge N accepts).
    task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        check({tag, " in_ready"}, in_ready_o, 1);
        in_valid_i = 1'b1;
        A_i = a; B_i = b; C_i = c;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check({tag, " classify out_valid"}, out_valid_o, 0);
        check({tag, " classify in_ready"}, in_ready_o, 0);
        @(negedge clk_i);
    endtask

    task automatic bypass_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] exp_res,
                               input logic exp_inv);
        send(tag, a, b, c);
        if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        check({tag, " out_valid"}, out_valid_o, 1);
        check({tag, " dp_start"}, dp_start_o, 0);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " invalid"}, invalid_o, exp_inv);
        check({tag, " bypass"}, bypass_o, 1);
        check({tag, " cnt"}, bypass_cnt_o, exp_cnt);
        @(negedge clk_i);
        check({tag, " done out_valid"}, out_valid_o, 0);
        check({tag, " done in_ready"}, in_ready_o, 1);
    endtask

    task automatic dp_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] dres);
        send(tag, a, b, c);
        check({tag, " dp_start"}, dp_start_o, 1);
        check({tag, " dp_A"}, dp_A_o, a);
        check({tag, " dp_B"}, dp_B_o, b);
        check({tag, " dp_C"}, dp_C_o, c);
        check({tag, " no bypass out"}, out_valid_o, 0);
        @(negedge clk_i);
        check({tag, " start pulse ends"}, dp_start_o, 0);
        @(negedge clk_i);
        check({tag, " wait out_valid"}, out_valid_o, 0);
        check({tag, " wait dp_A stable"}, dp_A_o, a);
        check({tag, " wait dp_C stable"}, dp_C_o, c);
        dp_done_i = 1'b1;
        dp_result_i = dres;
        @(posedge clk_i); #1;
        dp_done_i = 1'b0;
        dp_result_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check({tag, " out_valid"}, out_valid_o, 1);
        check({tag, " result"}, result_o, dres);
        check({tag, " bypass"}, bypass_o, 0);
        check({tag, " invalid"}, invalid_o, 0);
        check({tag, " cnt"}, bypass_cnt_o, exp_cnt);
        @(negedge clk_i);
        check({tag, " done in_ready"}, in_ready_o, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset in_ready", in_ready_o, 1);
        check("reset out_valid", out_valid_o, 0);
        check("reset dp_start", dp_start_o, 0);
        check("reset cnt", bypass_cnt_o, 0);
        check("reset result", result_o, 0);

        dp_case("normal", 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000);
        bypass_case("inf*0", 32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7FC0_0000, 1);
        bypass_case("0*inf", 32'h0000_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1);
        bypass_case("inf cancel", 32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1);
        bypass_case("snan C", 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000, 1);
        bypass_case("qnan C", 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 0);
        bypass_case("qnan+inf*0", 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1);
        bypass_case("prod -inf", 32'hFF80_0000, 32'h4000_0000, 32'h3F80_0000, 32'hFF80_0000, 0);
        bypass_case("inf same sign", 32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000, 32'hFF80_0000, 0);
        bypass_case("C inf", 32'h3F80_0000, 32'h4000_0000, 32'hFF80_0000, 32'hFF80_0000, 0);
        dp_case("denormal A", 32'h0000_0001, 32'h3F80_0000, 32'h4000_0000, 32'h1234_5678);
        dp_case("zeros", 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000);

        // A done pulse outside WAIT must not produce a result.
        dp_done_i = 1'b1;
        dp_result_i = 32'h5555_5555;
        @(posedge clk_i); #1;
        dp_done_i = 1'b0;
        @(negedge clk_i);
        check("idle done out_valid", out_valid_o, 0);
        check("idle done in_ready", in_ready_o, 1);

        out_ready_i = 1'b0;
        bypass_case_hold: begin
            send("stall", 32'h7F80_0000, 32'h4000_0000, 32'h3F80_0000);
            if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
            for (int i = 0; i < 10; i++) begin
                check("stall out_valid", out_valid_o, 1);
                check("stall result", result_o, 32'h7F80_0000);
                check("stall bypass", bypass_o, 1);
                check("stall invalid", invalid_o, 0);
                check("stall in_ready", in_ready_o, 0);
                @(negedge clk_i);
            end
            out_ready_i = 1'b1;
            @(negedge clk_i);
            check("stall release out_valid", out_valid_o, 0);
            check("stall release in_ready", in_ready_o, 1);
        end

        // Reset while waiting on the datapath, then a late done.
        send("midreset", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        check("midreset dp_start", dp_start_o, 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_cnt = '0;
        @(negedge clk_i);
        dp_done_i = 1'b1;
        dp_result_i = 32'h4040_0000;
        @(posedge clk_i); #1;
        dp_done_i = 1'b0;
        @(negedge clk_i);
        check("midreset in_ready", in_ready_o, 1);
        check("midreset out_valid", out_valid_o, 0);
        check("midreset cnt", bypass_cnt_o, 0);
        check("midreset result", result_o, 0);
        check("midreset dp_start", dp_start_o, 0);

        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            bypass_case("sat", 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 0);
        end
        check("sat final cnt", bypass_cnt_o, 32'h0000_001F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
